// File: rtl/mem_stage_if.sv
// Execute/memory-stage bus: EX-side operands and controls flowing into mem_stage,
// plus the MEM and WB results flowing back to the execute stage and register file.
interface mem_stage_if;
    // Pipeline control
    logic        STALL_MEM;
    logic        FLUSH_MEM;

    // Execute-stage results and controls
    logic [31:0] ALU_OUT_EX;
    logic [31:0] REG_DATA2_EX_FINAL;
    logic [31:0] PC_Branch_EX;
    logic        ZERO_EX;
    logic [4:0]  RD_EX;
    logic [2:0]  FUNCT3_EX;
    logic        RegWrite_EX;
    logic        MemtoReg_EX;
    logic        MemRead_EX;
    logic        MemWrite_EX;
    logic        Branch_EX;

    // Memory-stage outputs
    logic [31:0] ALU_OUT_MEM;
    logic [4:0]  RD_MEM;
    logic        RegWrite_MEM;
    logic [31:0] PC_Branch_MEM;
    logic        PCSrc_MEM;
    logic        MISALIGN_MEM;

    // Writeback-stage outputs
    logic [31:0] READ_DATA_WB;
    logic [31:0] ALU_OUT_WB;
    logic [4:0]  RD_WB;
    logic        RegWrite_WB;
    logic        MemtoReg_WB;
    logic [31:0] ALU_DATA_WB;

    // Execute side: drives operands, consumes results for forwarding and writeback
    modport master (
        output STALL_MEM, FLUSH_MEM,
        output ALU_OUT_EX, REG_DATA2_EX_FINAL, PC_Branch_EX, ZERO_EX, RD_EX, FUNCT3_EX,
        output RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX,
        input  ALU_OUT_MEM, RD_MEM, RegWrite_MEM, PC_Branch_MEM, PCSrc_MEM, MISALIGN_MEM,
        input  READ_DATA_WB, ALU_OUT_WB, RD_WB, RegWrite_WB, MemtoReg_WB, ALU_DATA_WB
    );

    // Memory stage itself
    modport slave (
        input  STALL_MEM, FLUSH_MEM,
        input  ALU_OUT_EX, REG_DATA2_EX_FINAL, PC_Branch_EX, ZERO_EX, RD_EX, FUNCT3_EX,
        input  RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX,
        output ALU_OUT_MEM, RD_MEM, RegWrite_MEM, PC_Branch_MEM, PCSrc_MEM, MISALIGN_MEM,
        output READ_DATA_WB, ALU_OUT_WB, RD_WB, RegWrite_WB, MemtoReg_WB, ALU_DATA_WB
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, byte-addressable data memory with
// byte/half/word stores and sign/zero-extended loads, branch resolution,
// MEM/WB register and the writeback mux.
module mem_stage #(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned DMEM_AW    = 10
) (
    input  logic      clk,
    input  logic      reset,
    mem_stage_if.slave bus
);

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [31:0] pc_branch;
        logic        zero;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [31:0] dmem_q [DMEM_DEPTH];

    logic [DMEM_AW-1:0] word_idx;
    logic [1:0]         lane;
    logic               half_access;
    logic               word_access;
    logic               misalign;
    logic               advance;
    logic               mem_we;
    logic [3:0]         byte_en;
    logic [31:0]        wdata;
    logic [31:0]        rword;
    logic [7:0]         rbyte;
    logic [15:0]        rhalf;
    logic [31:0]        load_data;
    logic               unused_addr_hi;

    // Upper address bits are deliberately ignored so addresses wrap around the memory.
    assign word_idx       = ex_mem_q.alu_out[DMEM_AW+1:2];
    assign lane           = ex_mem_q.alu_out[1:0];
    assign unused_addr_hi = ^ex_mem_q.alu_out[31:DMEM_AW+2];

    // A flush lets the MEM instruction retire even when a stall is also requested.
    assign advance = bus.FLUSH_MEM | ~bus.STALL_MEM;

    // Alignment check: halves need an even address, words a multiple of four.
    always_comb begin
        half_access = (ex_mem_q.mem_read &
                       ((ex_mem_q.funct3 == F3Half) | (ex_mem_q.funct3 == F3HalfU))) |
                      (ex_mem_q.mem_write & (ex_mem_q.funct3 == F3Half));
        word_access = (ex_mem_q.mem_read | ex_mem_q.mem_write) & (ex_mem_q.funct3 == F3Word);
        misalign    = (half_access & lane[0]) | (word_access & (lane != 2'b00));
    end

    // Store lane selection and replicated write data.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = ex_mem_q.store_data;
        unique case (ex_mem_q.funct3)
            F3Byte: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{ex_mem_q.store_data[7:0]}};
            end
            F3Half: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{ex_mem_q.store_data[15:0]}};
            end
            F3Word: begin
                byte_en = 4'b1111;
                wdata   = ex_mem_q.store_data;
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = ex_mem_q.store_data;
            end
        endcase
        mem_we = reset & advance & ex_mem_q.mem_write & ~misalign;
    end

    // Byte-enabled write into data memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    dmem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Combinational read with sign/zero extension; misaligned or unknown loads yield 0.
    always_comb begin
        rword     = dmem_q[word_idx];
        rbyte     = rword[{lane, 3'b000} +: 8];
        rhalf     = lane[1] ? rword[31:16] : rword[15:0];
        load_data = 32'h0;
        if (ex_mem_q.mem_read && !misalign) begin
            unique case (ex_mem_q.funct3)
                F3Byte:  load_data = {{24{rbyte[7]}}, rbyte};
                F3Half:  load_data = {{16{rhalf[15]}}, rhalf};
                F3Word:  load_data = rword;
                F3ByteU: load_data = {24'h0, rbyte};
                F3HalfU: load_data = {16'h0, rhalf};
                default: load_data = 32'h0;
            endcase
        end
    end

    // EX/MEM next state: flush inserts a bubble, stall holds, otherwise capture EX.
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (bus.FLUSH_MEM) begin
            ex_mem_d = '0;
        end else if (!bus.STALL_MEM) begin
            ex_mem_d.alu_out    = bus.ALU_OUT_EX;
            ex_mem_d.store_data = bus.REG_DATA2_EX_FINAL;
            ex_mem_d.pc_branch  = bus.PC_Branch_EX;
            ex_mem_d.zero       = bus.ZERO_EX;
            ex_mem_d.rd         = bus.RD_EX;
            ex_mem_d.funct3     = bus.FUNCT3_EX;
            ex_mem_d.reg_write  = bus.RegWrite_EX;
            ex_mem_d.mem_to_reg = bus.MemtoReg_EX;
            ex_mem_d.mem_read   = bus.MemRead_EX;
            ex_mem_d.mem_write  = bus.MemWrite_EX;
            ex_mem_d.branch     = bus.Branch_EX;
        end
    end

    // MEM/WB next state: retire the MEM instruction unless stalled.
    always_comb begin
        mem_wb_d = mem_wb_q;
        if (advance) begin
            mem_wb_d.read_data  = load_data;
            mem_wb_d.alu_out    = ex_mem_q.alu_out;
            mem_wb_d.rd         = ex_mem_q.rd;
            mem_wb_d.reg_write  = ex_mem_q.reg_write;
            mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.ALU_OUT_MEM   = ex_mem_q.alu_out;
    assign bus.RD_MEM        = ex_mem_q.rd;
    assign bus.RegWrite_MEM  = ex_mem_q.reg_write;
    assign bus.PC_Branch_MEM = ex_mem_q.pc_branch;
    assign bus.MISALIGN_MEM  = misalign;
    // BEQ takes on zero, BNE on non-zero; other branch types resolve elsewhere.
    assign bus.PCSrc_MEM     = ex_mem_q.branch &
                               (((ex_mem_q.funct3 == 3'b000) & ex_mem_q.zero) |
                                ((ex_mem_q.funct3 == 3'b001) & ~ex_mem_q.zero));

    assign bus.READ_DATA_WB  = mem_wb_q.read_data;
    assign bus.ALU_OUT_WB    = mem_wb_q.alu_out;
    assign bus.RD_WB         = mem_wb_q.rd;
    assign bus.RegWrite_WB   = mem_wb_q.reg_write;
    assign bus.MemtoReg_WB   = mem_wb_q.mem_to_reg;
    assign bus.ALU_DATA_WB   = mem_wb_q.mem_to_reg ? mem_wb_q.read_data : mem_wb_q.alu_out;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a transaction-level model predicts the outputs
// after every edge; a monitor compares them against the DUT.
module tb_mem_stage;

    localparam int unsigned Depth = 1024;
    localparam int unsigned Aw    = 10;
    localparam int unsigned Bytes = Depth * 4;

    logic clk = 1'b0;
    logic reset;

    mem_stage_if bus ();

    mem_stage #(.DMEM_DEPTH(Depth), .DMEM_AW(Aw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pcb;
        logic        zero;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        br;
    } instr_t;

    typedef struct packed {
        logic [31:0] alu_mem;
        logic [4:0]  rd_mem;
        logic        rw_mem;
        logic [31:0] pcb_mem;
        logic        pcsrc;
        logic        mis;
        logic [31:0] rdata_wb;
        logic [31:0] alu_wb;
        logic [4:0]  rd_wb;
        logic        rw_wb;
        logic        m2r_wb;
        logic [31:0] alu_data;
    } exp_t;

    // Reference model state
    instr_t      m_mem;
    logic [31:0] wb_read, wb_alu;
    logic [4:0]  wb_rd;
    logic        wb_rw, wb_m2r;
    logic [7:0]  mb [Bytes];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int unsigned acc_size(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ld_ok(logic [2:0] f3);
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic bit st_ok(logic [2:0] f3);
        return f3 inside {3'd0, 3'd1, 3'd2};
    endfunction

    function automatic bit misaligned(instr_t i);
        int unsigned a = i.alu % Bytes;
        bit acc = (i.mr && ld_ok(i.f3)) || (i.mw && st_ok(i.f3));
        return acc && (acc_size(i.f3) > 1) && ((a % acc_size(i.f3)) != 0);
    endfunction

    function automatic bit taken(instr_t i);
        return i.br && ((i.f3 == 3'd0 && i.zero) || (i.f3 == 3'd1 && !i.zero));
    endfunction

    function automatic logic [31:0] load_val(instr_t i);
        logic [31:0] v = 32'h0;
        int unsigned a = i.alu % Bytes;
        int unsigned n = acc_size(i.f3);
        if (!i.mr || !ld_ok(i.f3) || misaligned(i)) return 32'h0;
        for (int k = 0; k < int'(n); k++) v = v | (32'(mb[a + k]) << (8 * k));
        if (!i.f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Advance the model by one clock edge given the inputs presented before it.
    task automatic model_edge(instr_t x, bit stall, bit flush, bit rst, output exp_t e);
        if (!rst) begin
            m_mem   = '0;
            wb_read = 0; wb_alu = 0; wb_rd = 0; wb_rw = 0; wb_m2r = 0;
        end else begin
            if (flush || !stall) begin
                wb_read = load_val(m_mem);
                wb_alu  = m_mem.alu;
                wb_rd   = m_mem.rd;
                wb_rw   = m_mem.rw;
                wb_m2r  = m_mem.m2r;
                if (m_mem.mw && st_ok(m_mem.f3) && !misaligned(m_mem)) begin
                    for (int k = 0; k < int'(acc_size(m_mem.f3)); k++)
                        mb[(m_mem.alu % Bytes) + k] = m_mem.sdata[8*k +: 8];
                end
            end
            if (flush) m_mem = '0;
            else if (!stall) m_mem = x;
        end
        e.alu_mem  = m_mem.alu;
        e.rd_mem   = m_mem.rd;
        e.rw_mem   = m_mem.rw;
        e.pcb_mem  = m_mem.pcb;
        e.pcsrc    = taken(m_mem);
        e.mis      = misaligned(m_mem);
        e.rdata_wb = wb_read;
        e.alu_wb   = wb_alu;
        e.rd_wb    = wb_rd;
        e.rw_wb    = wb_rw;
        e.m2r_wb   = wb_m2r;
        e.alu_data = wb_m2r ? wb_read : wb_alu;
    endtask

    task automatic step(instr_t x, bit stall, bit flush, bit rst);
        exp_t e;
        @(negedge clk);
        reset                  = rst;
        bus.STALL_MEM          = stall;
        bus.FLUSH_MEM          = flush;
        bus.ALU_OUT_EX         = x.alu;
        bus.REG_DATA2_EX_FINAL = x.sdata;
        bus.PC_Branch_EX       = x.pcb;
        bus.ZERO_EX            = x.zero;
        bus.RD_EX              = x.rd;
        bus.FUNCT3_EX          = x.f3;
        bus.RegWrite_EX        = x.rw;
        bus.MemtoReg_EX        = x.m2r;
        bus.MemRead_EX         = x.mr;
        bus.MemWrite_EX        = x.mw;
        bus.Branch_EX          = x.br;
        model_edge(x, stall, flush, rst, e);
        exp_q.push_back(e);
    endtask

    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t st(logic [31:0] a, logic [31:0] d, logic [2:0] f3);
        instr_t i = '0;
        i.alu = a; i.sdata = d; i.f3 = f3; i.mw = 1'b1;
        return i;
    endfunction

    function automatic instr_t ld(logic [31:0] a, logic [2:0] f3, logic [4:0] rd);
        instr_t i = '0;
        i.alu = a; i.f3 = f3; i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t brn(logic [31:0] tgt, logic [2:0] f3, logic z);
        instr_t i = '0;
        i.pcb = tgt; i.f3 = f3; i.zero = z; i.br = 1'b1; i.rw = 1'b1; i.rd = 5'd3;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i = '0;
        logic [31:0] r = $urandom();
        int kind = $urandom_range(0, 3);
        i.alu = (r & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
        i.rd  = 5'($urandom_range(0, 31));
        i.pcb = $urandom();
        case (kind)
            0: begin i.mw = 1'b1; i.f3 = 3'($urandom_range(0, 3)); i.sdata = $urandom(); end
            1: begin i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.f3 = 3'($urandom_range(0, 7)); end
            2: begin i.rw = 1'b1; i.alu = $urandom(); end
            default: begin
                i.br = 1'b1; i.f3 = 3'($urandom_range(0, 2)); i.zero = 1'($urandom_range(0, 1));
            end
        endcase
        return i;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    // Monitor: every edge the DUT presents a new MEM/WB state; compare it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ALU_OUT_MEM",   bus.ALU_OUT_MEM,          e.alu_mem);
                chk("RD_MEM",        32'(bus.RD_MEM),          32'(e.rd_mem));
                chk("RegWrite_MEM",  32'(bus.RegWrite_MEM),    32'(e.rw_mem));
                chk("PC_Branch_MEM", bus.PC_Branch_MEM,        e.pcb_mem);
                chk("PCSrc_MEM",     32'(bus.PCSrc_MEM),       32'(e.pcsrc));
                chk("MISALIGN_MEM",  32'(bus.MISALIGN_MEM),    32'(e.mis));
                chk("READ_DATA_WB",  bus.READ_DATA_WB,         e.rdata_wb);
                chk("ALU_OUT_WB",    bus.ALU_OUT_WB,           e.alu_wb);
                chk("RD_WB",         32'(bus.RD_WB),           32'(e.rd_wb));
                chk("RegWrite_WB",   32'(bus.RegWrite_WB),     32'(e.rw_wb));
                chk("MemtoReg_WB",   32'(bus.MemtoReg_WB),     32'(e.m2r_wb));
                chk("ALU_DATA_WB",   bus.ALU_DATA_WB,          e.alu_data);
            end
        end
    end

    // Stimulus
    initial begin
        int budget;
        reset = 1'b0;
        bus.STALL_MEM = 0; bus.FLUSH_MEM = 0;
        bus.ALU_OUT_EX = 0; bus.REG_DATA2_EX_FINAL = 0; bus.PC_Branch_EX = 0;
        bus.ZERO_EX = 0; bus.RD_EX = 0; bus.FUNCT3_EX = 0; bus.RegWrite_EX = 0;
        bus.MemtoReg_EX = 0; bus.MemRead_EX = 0; bus.MemWrite_EX = 0; bus.Branch_EX = 0;
        for (int k = 0; k < int'(Bytes); k++) mb[k] = 8'h00;

        repeat (3) step(nop(), 0, 0, 0);

        // Initialise the low 64 bytes so every load reads defined data
        for (int w = 0; w < 16; w++) step(st(32'(w * 4), $urandom(), 3'd2), 0, 0, 1);
        step(nop(), 0, 0, 1);

        // Store then load back-to-back
        step(st(32'h10, 32'hDEAD_BEEF, 3'd2), 0, 0, 1);
        step(ld(32'h10, 3'd2, 5'd5), 0, 0, 1);
        repeat (2) step(nop(), 0, 0, 1);

        // Byte store into a known word, then signed/unsigned/word reads
        step(st(32'h10, 32'h1122_3344, 3'd2), 0, 0, 1);
        step(st(32'h13, 32'h0000_0080, 3'd0), 0, 0, 1);
        step(ld(32'h13, 3'd0, 5'd6), 0, 0, 1);
        step(ld(32'h13, 3'd4, 5'd7), 0, 0, 1);
        step(ld(32'h10, 3'd2, 5'd8), 0, 0, 1);
        repeat (2) step(nop(), 0, 0, 1);

        // Misaligned store and load
        step(st(32'h12, 32'hCAFE_F00D, 3'd2), 0, 0, 1);
        step(ld(32'h10, 3'd2, 5'd9), 0, 0, 1);
        step(ld(32'h11, 3'd1, 5'd10), 0, 0, 1);
        repeat (2) step(nop(), 0, 0, 1);

        // Branch taken, then the same branch flushed at its capture edge
        step(brn(32'h0000_1000, 3'd0, 1'b1), 0, 0, 1);
        step(nop(), 0, 0, 1);
        step(brn(32'h0000_2000, 3'd0, 1'b1), 0, 1, 1);
        step(brn(32'h0000_3000, 3'd1, 1'b0), 0, 0, 1);
        step(nop(), 0, 0, 1);

        // Stall with a store in MEM, then read back
        step(st(32'h20, 32'h55AA_55AA, 3'd2), 0, 0, 1);
        step(ld(32'h24, 3'd2, 5'd11), 1, 0, 1);
        step(ld(32'h24, 3'd2, 5'd11), 1, 0, 1);
        step(ld(32'h20, 3'd2, 5'd12), 0, 0, 1);
        step(nop(), 0, 0, 1);

        // Reset while a store sits in MEM: it must not write
        step(st(32'h24, 32'h1234_5678, 3'd2), 0, 0, 1);
        step(nop(), 0, 0, 0);
        step(ld(32'h24, 3'd2, 5'd13), 0, 0, 1);
        repeat (2) step(nop(), 0, 0, 1);

        // Wrap-around aliasing
        step(st(32'(4 * Depth + 8), 32'hA5A5_0F0F, 3'd2), 0, 0, 1);
        step(ld(32'h8, 3'd2, 5'd14), 0, 0, 1);
        repeat (2) step(nop(), 0, 0, 1);

        // Randomised traffic with occasional stall/flush/reset
        for (int n = 0; n < 400; n++) begin
            step(rand_instr(), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 49) != 0);
        end
        repeat (2) step(nop(), 0, 0, 1);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. Sits directly downstream of the execute stage and consumes its ALU result, store data, branch target and zero flag.
- Contains the EX/MEM pipeline register, an internal data memory with byte/half/word access, and branch resolution (PCSrc).
- Contains the MEM/WB pipeline register and the writeback mux. Its outputs ALU_OUT_MEM and ALU_DATA_WB feed the execute-stage forwarding muxes.

Parameters:
- DMEM_DEPTH, 1024, number of 32-bit words in data memory (power of two).
- DMEM_AW, 10, word-address width, equal to log2(DMEM_DEPTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- STALL_MEM  in  1  hold both pipeline registers; suppress memory write.
- FLUSH_MEM  in  1  load a bubble into EX/MEM.
- ALU_OUT_EX  in  32  ALU result, used as address or result.
- REG_DATA2_EX_FINAL  in  32  forwarded store data.
- PC_Branch_EX  in  32  branch target.
- ZERO_EX  in  1  ALU zero flag.
- RD_EX  in  5  destination register.
- FUNCT3_EX  in  3  access size / branch type.
- RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX  in  1 each  control bits.
- ALU_OUT_MEM  out  32  registered ALU result (forwarding source).
- RD_MEM  out  5  registered destination.
- RegWrite_MEM  out  1  registered RegWrite (forwarding unit).
- PC_Branch_MEM  out  32  registered branch target.
- PCSrc_MEM  out  1  branch taken.
- MISALIGN_MEM  out  1  misaligned access flag for the current MEM instruction.
- READ_DATA_WB  out  32  registered, extended load data.
- ALU_OUT_WB  out  32  registered ALU result.
- RD_WB  out  5  registered destination.
- RegWrite_WB, MemtoReg_WB  out  1 each  registered control bits.
- ALU_DATA_WB  out  32  writeback value.

Behaviour:
- Register update priority on each edge: reset low > FLUSH_MEM > STALL_MEM > normal load.
- Reset low: every EX/MEM and MEM/WB register field goes to 0. All registered outputs therefore read 0, PCSrc_MEM=0 and MISALIGN_MEM=0. Data memory contents are not cleared, and no write occurs while reset is low.
- FLUSH_MEM=1: EX/MEM loads all zeros (bubble). MEM/WB loads normally from the current MEM contents.
- STALL_MEM=1 (no flush): both registers hold their values and no memory write occurs. STALL_MEM has no effect when FLUSH_MEM=1.
- Latency: EX inputs sampled at edge N appear on the *_MEM outputs after edge N. The corresponding load data and WB controls appear after edge N+1.
- Memory address:
  - word index = ALU_OUT_MEM[DMEM_AW+1:2]; upper bits are ignored, so addresses wrap modulo DMEM_DEPTH*4.
  - byte lane = ALU_OUT_MEM[1:0].
- Stores (MemWrite_MEM=1) write at the rising edge:
  - funct3 000 (SB): byte into lane [1:0].
  - funct3 001 (SH): half into lane ALU_OUT_MEM[1].
  - funct3 010 (SW): full word.
  - Other funct3: no write, no flag.
  - Unwritten bytes of the word are preserved.
- Loads (MemRead_MEM=1), combinational read captured into READ_DATA_WB:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: word.
  - 100 LBU / 101 LHU: zero-extended.
  - Other funct3: 0.
  - When MemRead_MEM=0, READ_DATA_WB captures 0.
- Misalignment:
  - Condition: half access with ALU_OUT_MEM[0]=1, or word access with ALU_OUT_MEM[1:0]≠0, while MemRead_MEM or MemWrite_MEM is set.
  - MISALIGN_MEM=1 combinationally.
  - A misaligned store writes nothing; a misaligned load captures 0.
- Read-after-write: a store in MEM at cycle k followed by a load of the same address in MEM at cycle k+1 returns the new data.
- Branch: PCSrc_MEM = Branch_MEM & ((funct3==000 & ZERO_MEM) | (funct3==001 & ~ZERO_MEM)). It is combinational from the EX/MEM register and is 0 for any other funct3.
- ALU_DATA_WB = MemtoReg_WB ? READ_DATA_WB : ALU_OUT_WB (combinational).

Test Plan:
- SW 0xDEADBEEF at address 0x10, then LW 0x10 next cycle → READ_DATA_WB=0xDEADBEEF one edge after the load enters MEM; ALU_DATA_WB equal when MemtoReg_WB=1.
- SB 0x80 at 0x13 over word 0x11223344; then LB 0x13 → 0xFFFFFF80, LBU 0x13 → 0x00000080, LW 0x10 → 0x80223344.
- SW at 0x12 → MISALIGN_MEM=1 and the word at 0x10 is unchanged; LH at 0x11 → MISALIGN_MEM=1, READ_DATA_WB=0.
- Branch_EX=1, funct3=000, ZERO_EX=1 → PCSrc_MEM=1 with PC_Branch_MEM valid after one edge; same instruction with FLUSH_MEM=1 at that edge → PCSrc_MEM=0 and RegWrite_MEM=0.
- STALL_MEM held 2 cycles with a SW in MEM → a single write after release, registers unchanged during the stall; reset low mid-stream → all outputs 0 next edge and no memory write that cycle.
- Address 4*DMEM_DEPTH+8 aliases to address 8 (wrap-around check).
